// File: rtl/keypad_lock.sv
// keypad_lock: digit-code entry lock with timed unlock/fail/lockout indication
// and reprogramming of the stored code while unlocked.
module keypad_lock #(
  parameter int unsigned         DIGITS        = 4,
  parameter logic [DIGITS*4-1:0] DEFAULT_CODE  = 16'h1234,
  parameter int unsigned         ENTRY_TICKS   = 300,
  parameter int unsigned         HOLD_TICKS    = 100,
  parameter int unsigned         MAX_FAILS     = 3,
  parameter int unsigned         LOCKOUT_TICKS = 600
) (
  input  logic                clk_20Hz,
  input  logic                reset_n,
  input  logic                key_valid,
  input  logic [3:0]          key,
  output logic [DIGITS*4-1:0] entry,
  output logic [3:0]          digit_count,
  output logic                unlocked,
  output logic                fail,
  output logic                locked_out,
  output logic                prog_mode,
  output logic [3:0]          fail_count
);

  localparam int unsigned W      = DIGITS * 4;
  localparam int unsigned MAX_T1 = (ENTRY_TICKS > HOLD_TICKS) ? ENTRY_TICKS : HOLD_TICKS;
  localparam int unsigned MAX_T  = (MAX_T1 > LOCKOUT_TICKS) ? MAX_T1 : LOCKOUT_TICKS;
  localparam int unsigned TW     = $clog2(MAX_T + 1);

  localparam logic [3:0] KEY_PROG  = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hE;
  localparam logic [3:0] KEY_ENTER = 4'hF;

  localparam logic [3:0]    DIGITS_C    = 4'(DIGITS);
  localparam logic [3:0]    MAX_FAILS_C = 4'(MAX_FAILS);
  localparam logic [TW-1:0] ENTRY_LAST  = TW'(ENTRY_TICKS - 1);
  localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_TICKS - 1);
  localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCKOUT_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ENTRY    = 3'd1,
    S_UNLOCKED = 3'd2,
    S_FAIL     = 3'd3,
    S_LOCKOUT  = 3'd4,
    S_PROGRAM  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [W-1:0]  entry_q, entry_d;
  logic [W-1:0]  code_q, code_d;
  logic [3:0]    count_q, count_d;
  logic [3:0]    fails_q, fails_d;
  logic          unlocked_q, unlocked_d;
  logic          fail_q, fail_d;
  logic          locked_q, locked_d;
  logic          prog_q, prog_d;

  logic          is_digit, is_enter, is_clear, is_prog;
  logic          full, key_accept;
  logic          entry_expire, hold_expire, lock_expire;
  logic [W-1:0]  entry_shift;
  logic [3:0]    fails_inc;

  assign is_digit     = key_valid && (key <= 4'd9);
  assign is_enter     = key_valid && (key == KEY_ENTER);
  assign is_clear     = key_valid && (key == KEY_CLEAR);
  assign is_prog      = key_valid && (key == KEY_PROG);
  assign full         = (count_q == DIGITS_C);
  assign entry_expire = (timer_q == ENTRY_LAST);
  assign hold_expire  = (timer_q == HOLD_LAST);
  assign lock_expire  = (timer_q == LOCK_LAST);
  assign entry_shift  = (entry_q << 4) | W'(key);
  assign fails_inc    = fails_q + 4'd1;

  // Expiry is tested before any key so a key on the terminal cycle is dropped.
  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    count_d    = count_q;
    fails_d    = fails_q;
    code_d     = code_q;
    key_accept = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (is_digit) begin
          entry_d    = entry_shift;
          count_d    = count_q + 4'd1;
          key_accept = 1'b1;
          state_d    = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (entry_expire) begin
          state_d = S_IDLE;
        end else if (is_digit) begin
          if (!full) begin
            entry_d    = entry_shift;
            count_d    = count_q + 4'd1;
            key_accept = 1'b1;
          end
        end else if (is_enter) begin
          if (full && (entry_q == code_q)) begin
            fails_d = '0;
            state_d = S_UNLOCKED;
          end else begin
            fails_d = fails_inc;
            state_d = (fails_inc == MAX_FAILS_C) ? S_LOCKOUT : S_FAIL;
          end
        end else if (is_clear) begin
          state_d = S_IDLE;
        end
      end
      S_UNLOCKED: begin
        if (hold_expire) begin
          state_d = S_IDLE;
        end else if (is_prog) begin
          state_d = S_PROGRAM;
        end
      end
      S_FAIL: begin
        if (hold_expire) state_d = S_IDLE;
      end
      S_LOCKOUT: begin
        if (lock_expire) begin
          fails_d = '0;
          state_d = S_IDLE;
        end
      end
      S_PROGRAM: begin
        if (entry_expire) begin
          state_d = S_IDLE;
        end else if (is_digit) begin
          if (!full) begin
            entry_d    = entry_shift;
            count_d    = count_q + 4'd1;
            key_accept = 1'b1;
          end
        end else if (is_enter) begin
          if (full) code_d = entry_q;
          state_d = S_IDLE;
        end else if (is_clear) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Every transition except the one into ENTRY starts with an empty entry.
    if ((state_d != state_q) && (state_d != S_ENTRY)) begin
      entry_d = '0;
      count_d = '0;
    end
  end

  always_comb begin
    timer_d = timer_q;
    if ((state_d != state_q) || key_accept) begin
      timer_d = '0;
    end else if (timer_q != '1) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_comb begin
    unlocked_d = (state_d == S_UNLOCKED) || (state_d == S_PROGRAM);
    fail_d     = (state_d == S_FAIL);
    locked_d   = (state_d == S_LOCKOUT);
    prog_d     = (state_d == S_PROGRAM);
  end

  always_ff @(posedge clk_20Hz or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      entry_q    <= '0;
      count_q    <= '0;
      fails_q    <= '0;
      code_q     <= DEFAULT_CODE;
      unlocked_q <= 1'b0;
      fail_q     <= 1'b0;
      locked_q   <= 1'b0;
      prog_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      entry_q    <= entry_d;
      count_q    <= count_d;
      fails_q    <= fails_d;
      code_q     <= code_d;
      unlocked_q <= unlocked_d;
      fail_q     <= fail_d;
      locked_q   <= locked_d;
      prog_q     <= prog_d;
    end
  end

  assign entry       = entry_q;
  assign digit_count = count_q;
  assign unlocked    = unlocked_q;
  assign fail        = fail_q;
  assign locked_out  = locked_q;
  assign prog_mode   = prog_q;
  assign fail_count  = fails_q;

endmodule

// File: doc/keypad_lock.md
KEYPAD_LOCK -- requirements
Module: keypad_lock

Interface
REQ-001 Parameter DIGITS, default 4, code length in digits (legal range 1..8).
REQ-002 Parameter DEFAULT_CODE, default 16'h1234, reset code of DIGITS*4 bits with the first-entered digit in the MS nibble.
REQ-003 Parameter ENTRY_TICKS, default 300, inactivity timeout in ENTRY/PROGRAM (15 s at 20 Hz).
REQ-004 Parameter HOLD_TICKS, default 100, duration of UNLOCKED and FAIL indication (5 s).
REQ-005 Parameter MAX_FAILS, default 3, consecutive failures that trigger lockout (legal range 1..15).
REQ-006 Parameter LOCKOUT_TICKS, default 600, lockout duration (30 s).
REQ-007 clk_20Hz  input  1  sole clock; all state changes on its rising edge.
REQ-008 reset_n  input  1  asynchronous, active-low reset.
REQ-009 key_valid  input  1  one-cycle pulse marking a debounced key press.
REQ-010 key  input  4  key code, sampled only when key_valid=1; 0-9 digit, 4'hA program, 4'hE clear (*), 4'hF enter (#), others ignored.
REQ-011 entry  output  DIGITS*4  entered-digit shift register for the 7-segment displays, newest digit in [3:0].
REQ-012 digit_count  output  4  number of digits currently held in entry.
REQ-013 unlocked  output  1  high while in UNLOCKED or PROGRAM.
REQ-014 fail  output  1  high while in FAIL.
REQ-015 locked_out  output  1  high while in LOCKOUT.
REQ-016 prog_mode  output  1  high while in PROGRAM.
REQ-017 fail_count  output  4  consecutive failed attempts since the last success or lockout.

Function
REQ-018 States SHALL be IDLE, ENTRY, UNLOCKED, FAIL, LOCKOUT and PROGRAM; all outputs SHALL be registered.
REQ-019 A single tick counter SHALL clear on every state transition and on every accepted key, and SHALL otherwise increment once per cycle.
REQ-020 A digit key in IDLE or ENTRY SHALL shift entry left 4 bits, load the key into [3:0], increment digit_count and go to ENTRY, all on the next edge.
REQ-021 A digit key when digit_count==DIGITS SHALL be ignored, leaving entry, count and timer unchanged.
REQ-022 In ENTRY, # with digit_count==DIGITS and entry==stored code SHALL go to UNLOCKED and clear fail_count.
REQ-023 In ENTRY, any other # SHALL increment fail_count and go to FAIL, or to LOCKOUT if the new fail_count equals MAX_FAILS.
REQ-024 In ENTRY, * SHALL go to IDLE without counting a failure.
REQ-025 In ENTRY, ENTRY_TICKS cycles without an accepted key SHALL return to IDLE without counting a failure.
REQ-026 Every transition to IDLE, UNLOCKED, FAIL or LOCKOUT SHALL clear entry and digit_count to 0.
REQ-027 # or * in IDLE, and non-digit keys other than those listed per state, SHALL be ignored.
REQ-028 UNLOCKED SHALL last HOLD_TICKS cycles, then go to IDLE.
REQ-029 Key A in UNLOCKED SHALL go to PROGRAM, clearing entry and the timer.
REQ-030 In PROGRAM, digits SHALL be handled as in REQ-020 and REQ-021.
REQ-031 In PROGRAM, # with digit_count==DIGITS SHALL load entry into the stored code and go to IDLE.
REQ-032 In PROGRAM, # with fewer digits, *, or ENTRY_TICKS inactivity SHALL go to IDLE with the stored code unchanged.
REQ-033 FAIL SHALL last HOLD_TICKS cycles and LOCKOUT SHALL last LOCKOUT_TICKS cycles, each then going to IDLE; all keys are ignored in both states.
REQ-034 Exit from LOCKOUT SHALL clear fail_count.
REQ-035 If key_valid coincides with the timer terminal cycle, timer expiry SHALL win and the key SHALL be discarded.
REQ-036 The timer width SHALL be sized by $clog2 of the largest tick parameter + 1, so no count wraps before expiry.

Reset
REQ-037 While reset_n=0, state SHALL be IDLE, the stored code DEFAULT_CODE, and entry, digit_count, fail_count and all flag outputs 0, regardless of clock.
REQ-038 Reset asserted mid-operation (including PROGRAM or LOCKOUT) SHALL take effect immediately, and any partially programmed code SHALL be discarded.

Verification (DIGITS=4, ENTRY_TICKS=10, HOLD_TICKS=5, LOCKOUT_TICKS=8, MAX_FAILS=3)
REQ-039 Keys 1,2,3,4,# -> entry=16'h1234 before #; unlocked=1 for exactly 5 cycles; fail_count=0.
REQ-040 Keys 1,2,3,5,# three times -> fail pulses of 5 cycles after attempts 1 and 2; after attempt 3 locked_out=1 for 8 cycles with keys ignored; then fail_count=0.
REQ-041 Keys 1,2 then 10 idle cycles -> IDLE, entry=0, fail_count unchanged; keys 1,2,3,4,5 -> entry=16'h1234, count=4.
REQ-042 Unlock, A, 9,8,7,6,# -> prog_mode high, then IDLE; 1,2,3,4,# -> fail; 9,8,7,6,# -> unlocked.
REQ-043 key_valid on the timer terminal cycle -> key dropped; reset_n pulsed low in PROGRAM -> code reverts to 16'h1234 and all outputs 0 asynchronously.
